axis_stream_checker: RTL and testbench
======================================

Name: axis_stream_checker

Overview:
- AXI4-Stream sink placed directly downstream of the ZYNQ7PS test-pattern generator.
- Consumes fixed-length packets and checks each beat against the expected incrementing-index pattern.
- Also checks TKEEP and TLAST placement.
- Exposes packet/error counters and sticky error flags for PS readout during PL bring-up.

Parameters:
- AXIS_DATA_WIDTH, 256: TDATA width in bits; must be ≥ 10.
- AXIS_DATA_KEEP, 32: TKEEP width (AXIS_DATA_WIDTH/8).
- AXIS_DATA_DEPTH, 400: beats per packet, 1..1023.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  checker enable; low forces s_axis_tready low.
- s_axis_tdata  in  AXIS_DATA_WIDTH  stream data.
- s_axis_tkeep  in  AXIS_DATA_KEEP  byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  source data valid.
- s_axis_tready  out  1  sink ready.
- pkt_done  out  1  one-cycle pulse, packet closed.
- pkt_err  out  1  valid with pkt_done; closed packet had ≥1 error.
- pkt_cnt  out  16  packets closed, saturating.
- err_cnt  out  16  erroneous beats, saturating.
- err_flags  out  4  sticky: [0] data mismatch, [1] early TLAST, [2] missing TLAST, [3] TKEEP not all-ones.
- first_err_beat  out  10  beat index of first error since reset.
- busy  out  1  high while a packet is open (state RECV).

Behaviour:
- Reset (rst=1 at clk edge) is synchronous and active-high.
  - State IDLE; beat_idx=0.
  - Outputs pkt_done=0, pkt_err=0, pkt_cnt=0, err_cnt=0, err_flags=0, first_err_beat=0, busy=0.
  - Reset mid-packet abandons the packet; no pkt_done is issued.
- Beat accepted iff s_axis_tvalid && s_axis_tready.
- s_axis_tready = enable && (state != DONE) [&& throttle_phase, see Optional Feature].
  - Combinational from registered state; no dependency on tvalid.
- States:
  - IDLE: beat_idx=0. On an accepted beat, check it. Go to RECV, or to DONE if that beat terminates the packet.
  - RECV: busy=1. Each accepted beat is checked and beat_idx increments. A terminating beat moves to DONE.
  - DONE: exactly one cycle. tready=0, pkt_done=1, pkt_err = OR of all beat errors in the packet. pkt_cnt increments here. Returns to IDLE.
- Per-beat checks, with expected value = beat_idx zero-extended to AXIS_DATA_WIDTH:
  - tdata != expected sets flag[0].
  - tkeep != all-ones sets flag[3].
  - tlast=1 with beat_idx < DEPTH-1 sets flag[1] and terminates the packet.
  - tlast=0 with beat_idx == DEPTH-1 sets flag[2] and terminates the packet (resync).
  - tlast=1 with beat_idx == DEPTH-1 is a normal termination.
- A beat with several errors:
  - sets every matching flag;
  - increments err_cnt once;
  - latches first_err_beat only if err_cnt was 0.
- Counters saturate at 16'hFFFF.
- Latency: pkt_done asserts the cycle after the terminating beat is accepted.
- DEPTH=1: every beat goes IDLE→DONE; pkt_done rate is one per two cycles max.
- enable deasserted mid-packet: tready low, state and beat_idx held, packet resumes on re-enable.
- tvalid gaps are allowed anywhere; state holds without acceptance.

Optional Feature:
- Macro AXIS_CHECKER_BACKPRESSURE_EN.
- Defined:
  - A 1-bit throttle_phase register toggles every clock, reset to 1.
  - s_axis_tready is additionally gated by throttle_phase, giving at most one acceptance every two cycles.
  - This exercises upstream stall handling.
- Undefined:
  - The register is absent; tready depends only on enable and state.

Test Plan:
- Clean packet: enable=1; 400 beats, tdata=0..399, tkeep=all-ones, tlast on beat 399, with a one-cycle tvalid gap between beats.
  -> pkt_done pulses once, 1 cycle after beat 399; pkt_err=0, pkt_cnt=1, err_cnt=0, err_flags=0.
- Data corruption: beat 17 carries tdata=18, rest clean.
  -> err_flags=4'b0001, err_cnt=1, first_err_beat=17, pkt_done with pkt_err=1, pkt_cnt=1.
- Early TLAST: tlast on beat 199, then a clean 400-beat packet.
  -> flag[1] set, first pkt_done after beat 199 with pkt_err=1; second packet checked from index 0 with pkt_err=0; pkt_cnt=2, err_cnt=1.
- Missing TLAST + bad TKEEP: beat 399 sent with tlast=0 and tkeep=32'hFFFF_FFFE.
  -> err_flags=4'b1100, err_cnt=1, first_err_beat=399, pkt_done with pkt_err=1.
- Reset mid-packet: assert rst one cycle at beat 250, then send a clean 400-beat packet.
  -> no pkt_done for the aborted packet; all outputs 0 after reset; final pkt_cnt=1, err_cnt=0.
- With AXIS_CHECKER_BACKPRESSURE_EN: tvalid held high continuously for a clean packet.
  -> tready toggles every cycle; 400 beats accepted in 799–800 cycles; pkt_cnt=1, err_flags=0.

Source files
------------

// File: rtl/axis_stream_checker_if.sv
// rtl/axis_stream_checker_if.sv - AXI4-Stream sink-side bundle for the stream checker.
interface axis_stream_checker_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_stream_checker.sv
// rtl/axis_stream_checker.sv - incrementing-index packet checker with TKEEP/TLAST checks.
// Optional AXIS_CHECKER_BACKPRESSURE_EN gates tready every other cycle.
module axis_stream_checker #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_DATA_KEEP  = 32,
  parameter int AXIS_DATA_DEPTH = 400
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  axis_stream_checker_if.slave   s_axis,
  output logic                   pkt_done,
  output logic                   pkt_err,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            err_cnt,
  output logic [3:0]             err_flags,
  output logic [9:0]             first_err_beat,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_e;

  localparam logic [9:0] LAST_IDX = 10'(AXIS_DATA_DEPTH - 1);

  state_e      state_q, state_d;
  logic [9:0]  beat_idx_q, beat_idx_d;
  logic        pkt_err_q, pkt_err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [3:0]  err_flags_q, err_flags_d;
  logic [9:0]  first_err_q, first_err_d;

  logic tready;
  logic accept;
  logic data_err, keep_err, at_last, early_last, missing_last, beat_err, terminate;

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
  logic throttle_phase_q;

  always_ff @(posedge clk) begin
    if (rst) throttle_phase_q <= 1'b1;
    else     throttle_phase_q <= ~throttle_phase_q;
  end

  assign tready = enable && (state_q != DONE) && throttle_phase_q;
`else
  assign tready = enable && (state_q != DONE);
`endif

  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid && tready;

  assign data_err     = s_axis.tdata != AXIS_DATA_WIDTH'(beat_idx_q);
  assign keep_err     = s_axis.tkeep != {AXIS_DATA_KEEP{1'b1}};
  assign at_last      = beat_idx_q == LAST_IDX;
  assign early_last   = s_axis.tlast && !at_last;
  // A missing TLAST still closes the packet so the checker resyncs on the next index 0.
  assign missing_last = !s_axis.tlast && at_last;
  assign terminate    = s_axis.tlast || at_last;
  assign beat_err     = data_err || keep_err || early_last || missing_last;

  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    pkt_err_d   = pkt_err_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flags_d = err_flags_q;
    first_err_d = first_err_q;

    case (state_q)
      IDLE, RECV: begin
        if (accept) begin
          pkt_err_d = pkt_err_q | beat_err;
          if (terminate) begin
            state_d    = DONE;
            beat_idx_d = '0;
          end else begin
            state_d    = RECV;
            beat_idx_d = beat_idx_q + 10'd1;
          end
          if (beat_err) begin
            err_flags_d = err_flags_q | {keep_err, missing_last, early_last, data_err};
            if (err_cnt_q == 16'd0) first_err_d = beat_idx_q;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        pkt_err_d = 1'b0;
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      pkt_err_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      pkt_err_q   <= pkt_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_flags_q <= err_flags_d;
      first_err_q <= first_err_d;
    end
  end

  assign pkt_done       = state_q == DONE;
  assign pkt_err        = (state_q == DONE) && pkt_err_q;
  assign busy           = state_q == RECV;
  assign pkt_cnt        = pkt_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_flags      = err_flags_q;
  assign first_err_beat = first_err_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// tb/tb_axis_stream_checker.sv - table-driven bench for axis_stream_checker (DEPTH=400).
module tb_axis_stream_checker;

  localparam int DW    = 256;
  localparam int KW    = 32;
  localparam int DEPTH = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pkt_done, pkt_err, busy;
  logic [15:0] pkt_cnt, err_cnt;
  logic [3:0]  err_flags;
  logic [9:0]  first_err_beat;

  axis_stream_checker_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis ();

  axis_stream_checker #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_DATA_KEEP (KW),
    .AXIS_DATA_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .s_axis        (s_axis),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err),
    .pkt_cnt       (pkt_cnt),
    .err_cnt       (err_cnt),
    .err_flags     (err_flags),
    .first_err_beat(first_err_beat),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int done_total = 0;
  always @(posedge clk) if (pkt_done) done_total <= done_total + 1;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int          n_beats;
    int          bad_data;
    int          last_at;
    int          bad_keep;
    bit          gap;
    bit          exp_err;
    logic [3:0]  exp_flags;
    logic [15:0] exp_errcnt;
    logic [9:0]  exp_first;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input int data, input logic [KW-1:0] keep, input bit last, input bit gap);
    bit ok;
    @(negedge clk);
    if (gap) begin
      s_axis.tvalid = 1'b0;
      @(negedge clk);
    end
    s_axis.tdata  = DW'(data);
    s_axis.tkeep  = keep;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (s_axis.tready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL beat_timeout: beat %0d not accepted, got tready=0 expected 1", data);
    end
  endtask

  task automatic send_beats(input int first, input int last, input int bad_data,
                            input int last_at, input int bad_keep, input bit gap);
    for (int i = first; i <= last; i++)
      send_beat(i + ((i == bad_data) ? 1 : 0),
                (i == bad_keep) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF,
                i == last_at, gap);
  endtask

  task automatic finish_pkt(input string tag, input bit exp_err, output time t_done);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    t_done = $time;
    chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd1);
    chk({tag, "_pkt_err"}, 32'(pkt_err), 32'(exp_err));
    chk({tag, "_tready_done"}, 32'(s_axis.tready), 32'd0);
    @(negedge clk);
    chk({tag, "_pkt_done_clr"}, 32'(pkt_done), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst           = 1'b1;
    enable        = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_rst_done"}, 32'(pkt_done), 32'd0);
    chk({tag, "_rst_err"}, 32'(pkt_err), 32'd0);
    chk({tag, "_rst_pktcnt"}, 32'(pkt_cnt), 32'd0);
    chk({tag, "_rst_errcnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_rst_flags"}, 32'(err_flags), 32'd0);
    chk({tag, "_rst_first"}, 32'(first_err_beat), 32'd0);
    chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rst_tready"}, 32'(s_axis.tready), 32'd1);
  endtask

  initial begin
    int  d0;
    time t0, t1;
    rst           = 1'b1;
    enable        = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '1;
    s_axis.tlast  = 1'b0;
    s_axis.tvalid = 1'b0;

    //          beats bad_d last_at bad_k gap err flags    errcnt first
    vecs[0] = '{400,  -1,   399,    -1,   1,  0,  4'b0000, 16'd0, 10'd0};
    vecs[1] = '{400,  17,   399,    -1,   0,  1,  4'b0001, 16'd1, 10'd17};
    vecs[2] = '{200,  -1,   199,    -1,   0,  1,  4'b0010, 16'd1, 10'd199};
    vecs[3] = '{400,  -1,   -1,     399,  0,  1,  4'b1100, 16'd1, 10'd399};
    vecs[4] = '{400,  5,    399,    5,    0,  1,  4'b1001, 16'd1, 10'd5};
    vecs[5] = '{1,    -1,   0,      -1,   0,  1,  4'b0010, 16'd1, 10'd0};
    vecs[6] = '{400,  3,    399,    10,   1,  1,  4'b1001, 16'd2, 10'd3};

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("v%0d", v);
      do_reset(tag);
      d0 = done_total;
      send_beats(0, vecs[v].n_beats - 1, vecs[v].bad_data, vecs[v].last_at,
                 vecs[v].bad_keep, vecs[v].gap);
      finish_pkt(tag, vecs[v].exp_err, t1);
      chk({tag, "_done_pulses"}, 32'(done_total - d0), 32'd1);
      chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'd1);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(vecs[v].exp_errcnt));
      chk({tag, "_flags"}, 32'(err_flags), 32'(vecs[v].exp_flags));
      chk({tag, "_first"}, 32'(first_err_beat), 32'(vecs[v].exp_first));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
    end

    // Early TLAST followed by a clean packet: second packet must restart at index 0.
    do_reset("early");
    send_beats(0, 199, -1, 199, -1, 0);
    finish_pkt("early1", 1'b1, t1);
    send_beats(0, 399, -1, 399, -1, 0);
    finish_pkt("early2", 1'b0, t1);
    chk("early_pkt_cnt", 32'(pkt_cnt), 32'd2);
    chk("early_err_cnt", 32'(err_cnt), 32'd1);
    chk("early_flags", 32'(err_flags), 32'b0010);

    // Reset at beat 250 abandons the packet without a pkt_done.
    do_reset("mid");
    d0 = done_total;
    send_beats(0, 249, -1, 399, -1, 0);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    s_axis.tdata  = DW'(250);
    s_axis.tvalid = 1'b1;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    s_axis.tvalid = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(pkt_done), 32'd0);
    chk("mid_rst_pktcnt", 32'(pkt_cnt), 32'd0);
    send_beats(0, 399, -1, 399, -1, 0);
    finish_pkt("mid", 1'b0, t1);
    chk("mid_done_pulses", 32'(done_total - d0), 32'd1);
    chk("mid_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);

    // Enable dropped mid-packet: tready low, state held, packet resumes cleanly.
    do_reset("en");
    send_beats(0, 99, -1, 399, -1, 1);
    @(negedge clk);
    enable        = 1'b0;
    s_axis.tdata  = DW'(100);
    s_axis.tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("en_tready_low", 32'(s_axis.tready), 32'd0);
    end
    chk("en_busy_held", 32'(busy), 32'd1);
    enable        = 1'b1;
    s_axis.tvalid = 1'b0;
    send_beats(100, 399, -1, 399, -1, 0);
    finish_pkt("en", 1'b0, t1);
    chk("en_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("en_err_cnt", 32'(err_cnt), 32'd0);
    chk("en_flags", 32'(err_flags), 32'd0);

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    // Throttled tready: continuous tvalid gives one acceptance every two cycles.
    do_reset("bp");
    begin
      logic prev;
      prev = s_axis.tready;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("bp_tready_toggle", 32'(s_axis.tready), 32'(~prev));
        prev = s_axis.tready;
      end
    end
    t0 = $time + 10;
    send_beats(0, 399, -1, 399, -1, 0);
    finish_pkt("bp", 1'b0, t1);
    begin
      int cyc;
      cyc = int'((t1 - t0) / 10);
      n_vec++;
      if (cyc < 799 || cyc > 800) begin
        n_fail++;
        $display("FAIL bp_cycles: got %0d expected 799..800", cyc);
      end
    end
    chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("bp_flags", 32'(err_flags), 32'd0);
`else
    t0 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
